// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity-type and prescale constants,
// plus small helpers used by both the receiver and the transmitter.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [5:0] PRE_8  = 6'd8;
  localparam logic [5:0] PRE_16 = 6'd16;
  localparam logic [5:0] PRE_32 = 6'd32;

  // 2-of-3 vote over the mid-bit samples.
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Unsupported oversampling ratios fall back to x16.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    logic [5:0] r;
    case (p)
      PRE_8:   r = PRE_8;
      PRE_16:  r = PRE_16;
      PRE_32:  r = PRE_32;
      default: r = PRE_16;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Captures the synchronized line at the three mid-bit edge counts and
// presents their majority as the bit value.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_s,
  input  logic [5:0] i_edge,
  input  logic [5:0] i_pre,
  output logic       o_bit
);

  logic [5:0] w_mid;
  logic [2:0] r_smp;

  assign w_mid = {1'b0, i_pre[5:1]};

  // Sample slots are fully refreshed every bit, so no per-frame clear is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_smp <= 3'b111;
    end else begin
      if (i_edge == (w_mid - 6'd1)) r_smp[0] <= i_rx_s;
      if (i_edge == w_mid)          r_smp[1] <= i_rx_s;
      if (i_edge == (w_mid + 6'd1)) r_smp[2] <= i_rx_s;
    end
  end

  assign o_bit = majority3(r_smp);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: synchronizer, edge/bit counters, frame FSM,
// parity and stop checking with registered one-cycle result strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int dataWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic [5:0]           prescale,
  input  logic                 par_en,
  input  logic                 par_type,
  output logic [dataWidth-1:0] p_data,
  output logic                 data_valid,
  output logic                 par_err,
  output logic                 stp_err
);

  localparam int BCW = (dataWidth > 1) ? $clog2(dataWidth) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(dataWidth - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx_s;
  logic [2:0]           r_state;
  logic [5:0]           r_edge;
  logic [BCW-1:0]       r_bit;
  logic [5:0]           r_pre;
  logic                 r_pen;
  logic                 r_ptype;
  logic [dataWidth-1:0] r_shift;
  logic                 r_perr;
  logic                 w_bit_end;
  logic                 w_vote;
  logic [5:0]           w_pre_eff;

  assign w_rx_s    = r_sync2;
  assign w_bit_end = (r_edge == (r_pre - 6'd1));
  assign w_pre_eff = legal_prescale(prescale);

  // Two-flop synchronizer preset to the idle level so reset release is quiet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  uart_rx_sampler u_sampler (
    .clk    (clk),
    .rst    (rst),
    .i_rx_s (w_rx_s),
    .i_edge (r_edge),
    .i_pre  (r_pre),
    .o_bit  (w_vote)
  );

  // Frame sequencing, counters, shift register and latched frame configuration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_edge  <= 6'd0;
      r_bit   <= '0;
      r_pre   <= PRE_16;
      r_pen   <= 1'b0;
      r_ptype <= PAR_EVEN;
      r_shift <= '0;
      r_perr  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_edge <= 6'd0;
          r_bit  <= '0;
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_pre   <= w_pre_eff;
            r_pen   <= par_en;
            r_ptype <= par_type;
            r_perr  <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_edge  <= 6'd0;
            r_state <= w_vote ? ST_IDLE : ST_DATA;
          end else begin
            r_edge <= r_edge + 6'd1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_edge  <= 6'd0;
            r_shift <= {w_vote, r_shift[dataWidth-1:1]};
            if (r_bit == LAST_BIT) begin
              r_bit   <= '0;
              r_state <= r_pen ? ST_PARITY : ST_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_edge <= r_edge + 6'd1;
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_edge  <= 6'd0;
            r_perr  <= w_vote ^ (^r_shift) ^ (r_ptype == PAR_ODD);
            r_state <= ST_STOP;
          end else begin
            r_edge <= r_edge + 6'd1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_edge  <= 6'd0;
            r_state <= ST_DONE;
          end else begin
            r_edge <= r_edge + 6'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_edge  <= 6'd0;
          r_bit   <= '0;
        end
      endcase
    end
  end

  // Results are registered on the last stop-bit count so they coincide with DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if ((r_state == ST_STOP) && w_bit_end) begin
        par_err <= r_perr;
        stp_err <= ~w_vote;
        if (!r_perr && w_vote) begin
          p_data     <= r_shift;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// scored against a frame-level reference model.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_type;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int total = 0;
  int bad   = 0;

  int         n_valid = 0;
  int         n_perr  = 0;
  int         n_serr  = 0;
  logic [7:0] got[$];
  logic [7:0] exp_last = 8'h00;

  always #5 clk = ~clk;

  uart_rx #(.dataWidth(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_type   (par_type),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  // Strobe monitor: counts pulses and records each delivered byte.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      n_valid = n_valid + 1;
      got.push_back(p_data);
    end
    if (par_err === 1'b1) n_perr = n_perr + 1;
    if (stp_err === 1'b1) n_serr = n_serr + 1;
  end

  // Reference model: {valid, par_err, stp_err} produced by one frame.
  function automatic logic [2:0] model_frame(input logic pe, input logic flip, input logic stopb);
    logic perr;
    logic serr;
    perr = pe & flip;
    serr = ~stopb;
    return {~perr & ~serr, perr, serr};
  endfunction

  task automatic send_bit(input logic b, input int nclk);
    rx_in = b;
    repeat (nclk) @(posedge clk);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  // One frame at nclk clocks per bit; scramble flips the config pins mid-frame.
  task automatic send_frame(input logic [7:0] d, input int nclk, input logic pe, input logic pt,
                            input logic flip, input logic stopb, input logic scramble);
    logic [7:0] dd;
    dd = d;
    send_bit(1'b0, nclk);
    if (scramble) begin
      par_en   = ~par_en;
      par_type = ~par_type;
      prescale = 6'd24;
    end
    for (int i = 0; i < 8; i++) send_bit(dd[i], nclk);
    if (pe) send_bit((^dd) ^ pt ^ flip, nclk);
    send_bit(stopb, nclk);
    rx_in = 1'b1;
  endtask

  task automatic test_reset;
    int bv, bp, bs;
    rst = 1'b1; rx_in = 1'b1; prescale = 6'd16; par_en = 1'b0; par_type = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (p_data !== 8'h00) begin bad++; $display("FAIL reset_p_data: got %h want 00", p_data); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
    total++; if (par_err !== 1'b0) begin bad++; $display("FAIL reset_par_err: got %b want 0", par_err); end
    total++; if (stp_err !== 1'b0) begin bad++; $display("FAIL reset_stp_err: got %b want 0", stp_err); end
    bv = n_valid; bp = n_perr; bs = n_serr;
    @(negedge clk) rst = 1'b1;
    idle(60);
    total++; if ((n_valid - bv) + (n_perr - bp) + (n_serr - bs) !== 0) begin
      bad++; $display("FAIL reset_release_quiet: got %0d strobes want 0", (n_valid - bv) + (n_perr - bp) + (n_serr - bs));
    end
  endtask

  task automatic test_parity_ok;
    int bv, bp, bs;
    logic [2:0] m;
    prescale = 6'd8; par_en = 1'b1; par_type = 1'b0;
    bv = n_valid; bp = n_perr; bs = n_serr;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(12);
    m = model_frame(1'b1, 1'b0, 1'b1);
    if (m[2]) exp_last = 8'hA5;
    total++; if (n_valid - bv !== int'(m[2])) begin bad++; $display("FAIL par_ok_valid: got %0d want %0d", n_valid - bv, m[2]); end
    total++; if (p_data !== exp_last) begin bad++; $display("FAIL par_ok_data: got %h want %h", p_data, exp_last); end
    total++; if (n_perr - bp !== int'(m[1])) begin bad++; $display("FAIL par_ok_perr: got %0d want %0d", n_perr - bp, m[1]); end
    total++; if (n_serr - bs !== int'(m[0])) begin bad++; $display("FAIL par_ok_serr: got %0d want %0d", n_serr - bs, m[0]); end
  endtask

  task automatic test_parity_bad;
    int bv, bp, bs;
    prescale = 6'd8; par_en = 1'b1; par_type = 1'b0;
    bv = n_valid; bp = n_perr; bs = n_serr;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(12);
    total++; if (n_perr - bp !== 1) begin bad++; $display("FAIL par_bad_perr: got %0d want 1", n_perr - bp); end
    total++; if (n_valid - bv !== 0) begin bad++; $display("FAIL par_bad_valid: got %0d want 0", n_valid - bv); end
    total++; if (n_serr - bs !== 0) begin bad++; $display("FAIL par_bad_serr: got %0d want 0", n_serr - bs); end
    total++; if (p_data !== exp_last) begin bad++; $display("FAIL par_bad_hold: got %h want %h", p_data, exp_last); end
  endtask

  task automatic test_stop_err;
    int bv, bp, bs;
    prescale = 6'd16; par_en = 1'b0; par_type = 1'b0;
    bv = n_valid; bp = n_perr; bs = n_serr;
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(24);
    total++; if (n_serr - bs !== 1) begin bad++; $display("FAIL stop_err_serr: got %0d want 1", n_serr - bs); end
    total++; if (n_valid - bv !== 0) begin bad++; $display("FAIL stop_err_valid: got %0d want 0", n_valid - bv); end
    total++; if (n_perr - bp !== 0) begin bad++; $display("FAIL stop_err_perr: got %0d want 0", n_perr - bp); end
    total++; if (p_data !== exp_last) begin bad++; $display("FAIL stop_err_hold: got %h want %h", p_data, exp_last); end
  endtask

  task automatic test_glitch;
    int bv, bp, bs;
    prescale = 6'd8; par_en = 1'b0; par_type = 1'b0;
    bv = n_valid; bp = n_perr; bs = n_serr;
    send_bit(1'b0, 3);
    idle(40);
    total++; if ((n_valid - bv) + (n_perr - bp) + (n_serr - bs) !== 0) begin
      bad++; $display("FAIL glitch_quiet: got %0d strobes want 0", (n_valid - bv) + (n_perr - bp) + (n_serr - bs));
    end
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(12);
    exp_last = 8'h5A;
    total++; if (n_valid - bv !== 1) begin bad++; $display("FAIL glitch_next_valid: got %0d want 1", n_valid - bv); end
    total++; if (p_data !== exp_last) begin bad++; $display("FAIL glitch_next_data: got %h want %h", p_data, exp_last); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [10] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3C, 8'hC3, 8'h7E, 8'h81};
    int bv;
    prescale = 6'd32; par_en = 1'b1; par_type = 1'b0;
    bv = n_valid;
    for (int i = 0; i < 10; i++) send_frame(bytes[i], 32, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(48);
    total++; if (n_valid - bv !== 10) begin bad++; $display("FAIL b2b_count: got %0d want 10", n_valid - bv); end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bv + i >= got.size()) begin
        bad++; $display("FAIL b2b_byte%0d: got none want %h", i, bytes[i]);
      end else if (got[bv + i] !== bytes[i]) begin
        bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, got[bv + i], bytes[i]);
      end
    end
    exp_last = bytes[9];
  endtask

  task automatic test_reset_mid;
    int bv, bp, bs;
    prescale = 6'd16; par_en = 1'b0; par_type = 1'b0;
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
    send_bit(1'b1, 8);
    rst = 1'b0;
    #1;
    total++; if (p_data !== 8'h00) begin bad++; $display("FAIL midrst_p_data: got %h want 00", p_data); end
    total++; if ({data_valid, par_err, stp_err} !== 3'b000) begin
      bad++; $display("FAIL midrst_strobes: got %b want 000", {data_valid, par_err, stp_err});
    end
    exp_last = 8'h00;
    idle(4);
    @(negedge clk) rst = 1'b1;
    bv = n_valid; bp = n_perr; bs = n_serr;
    idle(40);
    total++; if ((n_valid - bv) + (n_perr - bp) + (n_serr - bs) !== 0) begin
      bad++; $display("FAIL midrst_quiet: got %0d strobes want 0", (n_valid - bv) + (n_perr - bp) + (n_serr - bs));
    end
    send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(24);
    exp_last = 8'hFF;
    total++; if (n_valid - bv !== 1) begin bad++; $display("FAIL midrst_next_valid: got %0d want 1", n_valid - bv); end
    total++; if (p_data !== exp_last) begin bad++; $display("FAIL midrst_next_data: got %h want %h", p_data, exp_last); end
  endtask

  task automatic test_prescale_illegal;
    int bv;
    prescale = 6'd5; par_en = 1'b0; par_type = 1'b0;
    bv = n_valid;
    send_frame(8'h96, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(24);
    exp_last = 8'h96;
    total++; if (n_valid - bv !== 1) begin bad++; $display("FAIL pre_default_valid: got %0d want 1", n_valid - bv); end
    total++; if (p_data !== exp_last) begin bad++; $display("FAIL pre_default_data: got %h want %h", p_data, exp_last); end
  endtask

  task automatic test_random;
    int bv, bp, bs, nclk;
    logic [7:0] d;
    logic pe, pt, flip, stopb, scr;
    logic [2:0] m;
    for (int k = 0; k < 14; k++) begin
      case ($urandom_range(0, 2))
        0: nclk = 8;
        1: nclk = 16;
        default: nclk = 32;
      endcase
      d     = 8'($urandom);
      pe    = 1'($urandom_range(0, 1));
      pt    = 1'($urandom_range(0, 1));
      flip  = ($urandom_range(0, 3) == 0);
      stopb = ($urandom_range(0, 4) != 0);
      scr   = ($urandom_range(0, 2) == 0);
      prescale = 6'(nclk); par_en = pe; par_type = pt;
      bv = n_valid; bp = n_perr; bs = n_serr;
      send_frame(d, nclk, pe, pt, flip, stopb, scr);
      idle(nclk + int'($urandom_range(0, nclk)));
      m = model_frame(pe, flip, stopb);
      if (m[2]) exp_last = d;
      total++; if (n_valid - bv !== int'(m[2])) begin bad++; $display("FAIL rnd%0d_valid: got %0d want %0d", k, n_valid - bv, m[2]); end
      total++; if (n_perr - bp !== int'(m[1])) begin bad++; $display("FAIL rnd%0d_perr: got %0d want %0d", k, n_perr - bp, m[1]); end
      total++; if (n_serr - bs !== int'(m[0])) begin bad++; $display("FAIL rnd%0d_serr: got %0d want %0d", k, n_serr - bs, m[0]); end
      total++; if (p_data !== exp_last) begin bad++; $display("FAIL rnd%0d_data: got %h want %h", k, p_data, exp_last); end
    end
  endtask

  initial begin
    test_reset;
    test_parity_ok;
    test_parity_bad;
    test_stop_err;
    test_glitch;
    test_back_to_back;
    test_reset_mid;
    test_prescale_illegal;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter dataWidth, default 8, giving the payload bits per frame.
REQ-002 SHALL have port clk, input, 1, the single clock (oversampling clock, prescale x bit rate).
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port rx_in, input, 1, the serial line (idle high), asynchronous to clk.
REQ-005 SHALL have port prescale, input, 6, the oversampling ratio; legal values are 8, 16 and 32.
REQ-006 SHALL have port par_en, input, 1; when 1, a parity bit follows the data bits.
REQ-007 SHALL have port par_type, input, 1; 0 selects even parity, 1 selects odd parity.
REQ-008 SHALL have port p_data, output, dataWidth, the last correctly received payload.
REQ-009 SHALL have port data_valid, output, 1, a one-cycle strobe marking p_data as new.
REQ-010 SHALL have port par_err, output, 1, a one-cycle strobe for a parity mismatch.
REQ-011 SHALL have port stp_err, output, 1, a one-cycle strobe for a stop bit sampled as 0.

Function
REQ-012 SHALL pass rx_in through a 2-flop synchronizer; all later timing refers to the synchronized line (rx_s).
REQ-013 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP and DONE.
REQ-014 SHALL leave IDLE for START on the first cycle with rx_s == 0, clearing the edge counter and bit counter.
REQ-015 SHALL run an edge counter from 0 to prescale-1 once per bit period, wrapping to 0 at the end of each bit.
REQ-016 SHALL sample rx_s at edge counts prescale/2-1, prescale/2 and prescale/2+1, and SHALL take the bit value as the 2-of-3 majority.
REQ-017 SHALL, in START, return to IDLE with no output strobe when the voted start bit is 1 (glitch rejection).
REQ-018 SHALL receive dataWidth data bits LSB first in DATA, shifting them into an internal register.
REQ-019 SHALL pass through PARITY only when par_en == 1, and SHALL compare the voted parity bit against ^data (even) or ~^data (odd).
REQ-020 SHALL latch prescale, par_en and par_type at the start-bit detection and hold them for the whole frame.
REQ-021 SHALL, after the final edge count of STOP, enter DONE for exactly one cycle.
REQ-022 SHALL, in DONE, with no error, load p_data from the shift register and pulse data_valid high for that one cycle.
REQ-023 SHALL, in DONE, on a parity error, pulse par_err, leave p_data unchanged and keep data_valid low.
REQ-024 SHALL, in DONE, on a stop-bit error, pulse stp_err, leave p_data unchanged and keep data_valid low.
REQ-025 SHALL, when parity and stop errors occur together, pulse both par_err and stp_err in the same cycle.
REQ-026 SHALL leave DONE for START when rx_s == 0 in that cycle (back-to-back frames), otherwise for IDLE.
REQ-027 SHALL treat any prescale value other than 8, 16 or 32 as 16.
REQ-028 SHALL hold p_data stable between data_valid pulses.

Reset
REQ-029 SHALL, on rst low at any time (including mid-frame), immediately force the FSM to IDLE and clear all counters.
REQ-030 SHALL, on rst low, set p_data = 0, data_valid = 0, par_err = 0 and stp_err = 0.
REQ-031 SHALL, on rst low, preset both synchronizer flops to 1.
REQ-032 SHALL, when rst deasserts while the line is idle, cause no spurious frame.

Structure
REQ-033 SHALL keep the FSM state encoding, the parity-type constants (EVEN = 0, ODD = 1) and the legal prescale constants in the shared uart package, which the transmitter also uses.
REQ-034 SHALL place the 3-sample majority-vote logic in one sub-module, uart_rx_sampler; the edge/bit counters, parity check and FSM stay in uart_rx.

Verification
REQ-035 SHALL cover this scenario: prescale = 8, par_en = 1, par_type = 0, frame 0 | A5 LSB-first | parity 0 | stop 1 -> one data_valid pulse, p_data = 8'hA5, par_err = 0, stp_err = 0.
REQ-036 SHALL cover this scenario: same frame with the parity bit set to 1 -> par_err pulses once, data_valid stays 0, p_data keeps its previous value.
REQ-037 SHALL cover this scenario: prescale = 16, par_en = 0, data 8'h3C, stop bit driven 0 -> stp_err pulses once, no data_valid.
REQ-038 SHALL cover this scenario: a 3-clk low glitch on the idle line with prescale = 8 -> FSM returns to IDLE, no strobes, the next valid frame (8'h5A) is received correctly.
REQ-039 SHALL cover this scenario: the 10 bench testcase bytes sent back-to-back by uartTX_top looped to rx_in, prescale = 32, even parity -> 10 data_valid pulses whose p_data matches each byte in order.
REQ-040 SHALL cover this scenario: rst pulsed low during DATA bit 4 -> all outputs 0 immediately, and the following complete frame 8'hFF is received with data_valid.
